regfile_2r1w: RTL and testbench

- 32-entry x 32-bit register file with two independent read ports (rs1, rs2) and one write port, all synchronous to a single clock.
- Serves as the integer register file of the core datapath. Operand addresses come from decode and write-back data comes from the WB stage.
- Read outputs are registered and only update when read_en is asserted.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_2r1w_if.sv | 24 ++
 rtl/regfile_read_port.sv | 49 ++++
 rtl/regfile_2r1w.sv | 54 +++++
 tb/tb_regfile_2r1w.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read / 1-write integer register file.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Operand-read and write-back bus of the register file; decode/WB drive it as master.
interface regfile_2r1w_if;
  import regfile_pkg::*;

  logic      read_en;
  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  logic      write_en;
  reg_addr_t write_addr;
  reg_data_t write_data;
  reg_data_t rs1_data;
  reg_data_t rs2_data;

  modport master (
    output read_en, rs1_addr, rs2_addr, write_en, write_addr, write_data,
    input  rs1_data, rs2_data
  );

  modport slave (
    input  read_en, rs1_addr, rs2_addr, write_en, write_addr, write_data,
    output rs1_data, rs2_data
  );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: entry select, write-first bypass, zero-register mask,
// and an output register that only loads while read_en is high.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter bit ZERO_REG = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_read_en,
  input  reg_addr_t i_addr,
  input  reg_data_t i_mem [NUM_REGS],
  input  logic      i_wr_en,
  input  reg_addr_t i_wr_addr,
  input  reg_data_t i_wr_data,
  output reg_data_t o_data
);

  logic      w_bypass;
  logic      w_is_zero;
  reg_data_t w_rd_data;
  reg_data_t r_data;

  // Select the value this port would capture on the coming edge.
  always_comb begin
    w_bypass  = i_wr_en && (i_wr_addr == i_addr);
    w_is_zero = (ZERO_REG == 1'b1) && (i_addr == {ADDR_W{1'b0}});
    w_rd_data = {DATA_W{1'b0}};
    if (w_is_zero) begin
      w_rd_data = {DATA_W{1'b0}};
    end else if (w_bypass) begin
      w_rd_data = i_wr_data;
    end else begin
      w_rd_data = i_mem[i_addr];
    end
  end

  // Output register: cleared by reset, otherwise loads only on enabled reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= {DATA_W{1'b0}};
    end else if (i_read_en) begin
      r_data <= w_rd_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x 32 integer register file: storage and write logic here, two read-port instances.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter bit ZERO_REG = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  regfile_2r1w_if.slave  bus
);

  reg_data_t r_mem [NUM_REGS];
  logic      w_wr_en;

  // Writes to entry 0 are dropped when it is hardwired to zero.
  assign w_wr_en = bus.write_en &&
                   !((ZERO_REG == 1'b1) && (bus.write_addr == {ADDR_W{1'b0}}));

  // Storage: synchronous clear on reset, single write port otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wr_en) begin
      r_mem[bus.write_addr] <= bus.write_data;
    end
  end

  regfile_read_port #(.ZERO_REG(ZERO_REG)) u_rs1 (
    .clk       (clk),
    .rst       (rst),
    .i_read_en (bus.read_en),
    .i_addr    (bus.rs1_addr),
    .i_mem     (r_mem),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (bus.write_addr),
    .i_wr_data (bus.write_data),
    .o_data    (bus.rs1_data)
  );

  regfile_read_port #(.ZERO_REG(ZERO_REG)) u_rs2 (
    .clk       (clk),
    .rst       (rst),
    .i_read_en (bus.read_en),
    .i_addr    (bus.rs2_addr),
    .i_mem     (r_mem),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (bus.write_addr),
    .i_wr_data (bus.write_data),
    .o_data    (bus.rs2_data)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed vector table, ZERO_REG sequence, and random traffic
// checked against an array model of the register file.
module tb_regfile_2r1w;
  import regfile_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0;
  logic rst1;
  regfile_2r1w_if if0 ();
  regfile_2r1w_if if1 ();

  regfile_2r1w #(.ZERO_REG(1'b0)) dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  regfile_2r1w #(.ZERO_REG(1'b1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic      rst;
    logic      re;
    reg_addr_t a1;
    reg_addr_t a2;
    logic      we;
    reg_addr_t wa;
    reg_data_t wd;
    reg_data_t e1;
    reg_data_t e2;
  } vec_t;

  vec_t vecs [19];

  logic [31:0] m_mem [2][NUM_REGS];
  logic [31:0] m_out [2][2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic r, input logic re, input reg_addr_t a1, input reg_addr_t a2,
                        input logic we, input reg_addr_t wa, input reg_data_t wd);
    rst0 = r; if0.read_en = re; if0.rs1_addr = a1; if0.rs2_addr = a2;
    if0.write_en = we; if0.write_addr = wa; if0.write_data = wd;
  endtask

  task automatic drive1(input logic r, input logic re, input reg_addr_t a1, input reg_addr_t a2,
                        input logic we, input reg_addr_t wa, input reg_data_t wd);
    rst1 = r; if1.read_en = re; if1.rs1_addr = a1; if1.rs2_addr = a2;
    if1.write_en = we; if1.write_addr = wa; if1.write_data = wd;
  endtask

  // Model of one edge: apply the write to the array, then reads see the updated array.
  task automatic model_edge(input int k, input bit zr, input logic r, input logic re,
                            input int a1, input int a2, input logic we, input int wa,
                            input logic [31:0] wd);
    if (r) begin
      for (int i = 0; i < NUM_REGS; i++) m_mem[k][i] = 32'h0;
      m_out[k][0] = 32'h0;
      m_out[k][1] = 32'h0;
    end else begin
      if (we && !(zr && wa == 0)) m_mem[k][wa] = wd;
      if (re) begin
        m_out[k][0] = (zr && a1 == 0) ? 32'h0 : m_mem[k][a1];
        m_out[k][1] = (zr && a2 == 0) ? 32'h0 : m_mem[k][a2];
      end
    end
  endtask

  initial begin
    drive0(1'b1, 1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 32'h0);
    drive1(1'b1, 1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 32'h0);

    //            rst   re    a1     a2     we    wa     wd            e1            e2
    vecs[0]  = '{1'b1, 1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 32'h0,        32'h0,        32'h0};
    vecs[2]  = '{1'b0, 1'b1, 5'h15, 5'h11, 1'b0, 5'h00, 32'h0,        32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 5'h15, 32'h0000ABCD, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 5'h14, 32'h0000A0CD, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 5'h13, 32'h00000BCD, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 5'h12, 32'h0000AB0D, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 5'h11, 32'h0000ABC0, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, 1'b1, 5'h15, 5'h11, 1'b0, 5'h00, 32'h0,        32'h0000ABCD, 32'h0000ABC0};
    vecs[9]  = '{1'b0, 1'b1, 5'h14, 5'h12, 1'b0, 5'h00, 32'h0,        32'h0000A0CD, 32'h0000AB0D};
    vecs[10] = '{1'b0, 1'b1, 5'h13, 5'h13, 1'b0, 5'h00, 32'h0,        32'h00000BCD, 32'h00000BCD};
    vecs[11] = '{1'b0, 1'b1, 5'h12, 5'h14, 1'b0, 5'h00, 32'h0,        32'h0000AB0D, 32'h0000A0CD};
    vecs[12] = '{1'b0, 1'b1, 5'h11, 5'h15, 1'b0, 5'h00, 32'h0,        32'h0000ABC0, 32'h0000ABCD};
    vecs[13] = '{1'b0, 1'b1, 5'h15, 5'h15, 1'b0, 5'h00, 32'h0,        32'h0000ABCD, 32'h0000ABCD};
    vecs[14] = '{1'b0, 1'b0, 5'h11, 5'h12, 1'b0, 5'h00, 32'h0,        32'h0000ABCD, 32'h0000ABCD};
    vecs[15] = '{1'b0, 1'b1, 5'h12, 5'h13, 1'b1, 5'h12, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000BCD};
    vecs[16] = '{1'b0, 1'b1, 5'h12, 5'h12, 1'b0, 5'h00, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[17] = '{1'b1, 1'b1, 5'h15, 5'h12, 1'b0, 5'h00, 32'h0,        32'h0,        32'h0};
    vecs[18] = '{1'b0, 1'b1, 5'h15, 5'h11, 1'b0, 5'h00, 32'h0,        32'h0,        32'h0};

    for (int i = 0; i < 19; i++) begin
      drive0(vecs[i].rst, vecs[i].re, vecs[i].a1, vecs[i].a2,
             vecs[i].we, vecs[i].wa, vecs[i].wd);
      step();
      chk($sformatf("vec%0d_rs1", i), if0.rs1_data, vecs[i].e1);
      chk($sformatf("vec%0d_rs2", i), if0.rs2_data, vecs[i].e2);
    end

    // Hardwired-zero instance: writes to entry 0 vanish, even through the bypass.
    drive1(1'b1, 1'b0, 5'h00, 5'h00, 1'b0, 5'h00, 32'h0);
    step();
    drive1(1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 5'h00, 32'h12345678);
    step();
    drive1(1'b0, 1'b1, 5'h00, 5'h00, 1'b0, 5'h00, 32'h0);
    step();
    chk("zr_read0_rs1", if1.rs1_data, 32'h0);
    chk("zr_read0_rs2", if1.rs2_data, 32'h0);
    drive1(1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 5'h01, 32'h12345678);
    step();
    drive1(1'b0, 1'b1, 5'h01, 5'h00, 1'b0, 5'h00, 32'h0);
    step();
    chk("zr_read1_rs1", if1.rs1_data, 32'h12345678);
    chk("zr_read1_rs2", if1.rs2_data, 32'h0);
    drive1(1'b0, 1'b1, 5'h00, 5'h01, 1'b1, 5'h00, 32'hFFFFFFFF);
    step();
    chk("zr_bypass0_rs1", if1.rs1_data, 32'h0);
    chk("zr_bypass0_rs2", if1.rs2_data, 32'h12345678);

    // Random traffic on both instances, first cycle forced into reset.
    for (int n = 0; n < 400; n++) begin
      logic        r, re, we;
      int          a1, a2, wa;
      logic [31:0] wd;
      r  = (n == 0) || ($urandom_range(0, 31) == 0);
      re = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) == 1);
      a1 = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31);
      a2 = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31);
      wa = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31);
      wd = $urandom;
      drive0(r, re, a1[4:0], a2[4:0], we, wa[4:0], wd);
      drive1(r, re, a1[4:0], a2[4:0], we, wa[4:0], wd);
      step();
      model_edge(0, 1'b0, r, re, a1, a2, we, wa, wd);
      model_edge(1, 1'b1, r, re, a1, a2, we, wa, wd);
      chk($sformatf("rnd%0d_z0_rs1", n), if0.rs1_data, m_out[0][0]);
      chk($sformatf("rnd%0d_z0_rs2", n), if0.rs2_data, m_out[0][1]);
      chk($sformatf("rnd%0d_z1_rs1", n), if1.rs1_data, m_out[1][0]);
      chk($sformatf("rnd%0d_z1_rs2", n), if1.rs2_data, m_out[1][1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
